alu_chunked: RTL and testbench

//  Parametrised successor to the one-by-one ALU front end. Shares a narrow

---
 rtl/alu_chunked.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_chunked.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_chunked.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_chunked
//  Description : Chunk-serial ALU front end. One narrow bus and push-button
//                are shared between operand entry (A then B, LSB chunk
//                first, then shift amount, then function code) and result
//                display (one result chunk per press).
//                Optional flag logic is enabled by defining ALU_FLAGS_EN;
//                without it the flags output is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_chunked #(
    parameter int DATA_W = 32,
    parameter int BUS_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] in,
    input  logic             btn,
    output logic [BUS_W-1:0] out,
    output logic [2:0]       phase,
    output logic             valid,
    output logic [3:0]       flags
);

    localparam int CHUNKS = DATA_W / BUS_W;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int SH_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(CHUNKS - 1);

    localparam logic [3:0] c_FN_ADD = 4'd0;
    localparam logic [3:0] c_FN_SUB = 4'd1;
    localparam logic [3:0] c_FN_AND = 4'd2;
    localparam logic [3:0] c_FN_OR  = 4'd3;
    localparam logic [3:0] c_FN_XOR = 4'd4;
    localparam logic [3:0] c_FN_NOT = 4'd5;
    localparam logic [3:0] c_FN_SLA = 4'd6;
    localparam logic [3:0] c_FN_SRA = 4'd7;
    localparam logic [3:0] c_FN_SRL = 4'd8;

    // Encodings double as the visible phase number
    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_SH = 3'd2,
        S_LOAD_FN = 3'd3,
        S_COMPUTE = 3'd4,
        S_SHOW    = 3'd5
    } state_t;

    state_t                        r_state;
    logic [IDX_W-1:0]              r_idx;
    logic [CHUNKS-1:0][BUS_W-1:0]  r_a;
    logic [CHUNKS-1:0][BUS_W-1:0]  r_b;
    logic [SH_W-1:0]               r_sh;
    logic [3:0]                    r_fn;
    logic [CHUNKS-1:0][BUS_W-1:0]  r_result;
    logic [BUS_W-1:0]              r_out;
    logic                          r_valid;
    logic                          r_btn_q;

    logic                          w_press;
    logic [IDX_W-1:0]              w_idx_inc;
    logic                          w_idx_last;
    logic [DATA_W-1:0]             w_a;
    logic [DATA_W-1:0]             w_b;
    logic [DATA_W-1:0]             w_result;

    // Rising edge of the (already debounced) button level
    assign w_press    = btn & ~r_btn_q;
    assign w_idx_inc  = r_idx + 1'b1;
    assign w_idx_last = (r_idx == c_LAST_IDX);
    assign w_a        = r_a;
    assign w_b        = r_b;

    // Result datapath, evaluated continuously and captured in COMPUTE
    always_comb begin
        w_result = '0;
        case (r_fn)
            c_FN_ADD: w_result = w_a + w_b;
            c_FN_SUB: w_result = w_a + ~w_b + 1'b1;
            c_FN_AND: w_result = w_a & w_b;
            c_FN_OR:  w_result = w_a | w_b;
            c_FN_XOR: w_result = w_a ^ w_b;
            c_FN_NOT: w_result = ~w_a;
            c_FN_SLA: w_result = w_a << r_sh;
            c_FN_SRA: w_result = $signed(w_a) >>> r_sh;
            c_FN_SRL: w_result = w_a >> r_sh;
            default:  w_result = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] r_flags;
    logic [3:0] w_flags;
    logic       w_carry;
    logic       w_ovf;
    logic       w_a_msb;
    logic       w_b_msb;
    logic       w_nb_msb;
    logic       w_r_msb;

    assign w_a_msb  = w_a[DATA_W-1];
    assign w_b_msb  = w_b[DATA_W-1];
    assign w_nb_msb = ~w_b[DATA_W-1];
    assign w_r_msb  = w_result[DATA_W-1];

    // Carry/overflow recovered from operand and result MSBs; shifts report
    // the last bit pushed out of the word
    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_fn)
            c_FN_ADD: begin
                w_carry = (w_a_msb & w_b_msb) | ((w_a_msb | w_b_msb) & ~w_r_msb);
                w_ovf   = (w_a_msb == w_b_msb) & (w_r_msb != w_a_msb);
            end
            c_FN_SUB: begin
                w_carry = (w_a_msb & w_nb_msb) | ((w_a_msb | w_nb_msb) & ~w_r_msb);
                w_ovf   = (w_a_msb != w_b_msb) & (w_r_msb != w_a_msb);
            end
            c_FN_SLA: begin
                if (r_sh != '0)
                    w_carry = w_a[SH_W'(DATA_W - int'(r_sh))];
            end
            c_FN_SRA, c_FN_SRL: begin
                if (r_sh != '0)
                    w_carry = w_a[r_sh - 1'b1];
            end
            default: begin
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
        w_flags = {w_r_msb, (w_result == '0), w_carry, w_ovf};
    end

    assign flags = r_flags;
`else
    assign flags = 4'b0000;
`endif

    // Phase sequencer: operand entry, one-cycle compute, chunked display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_LOAD_A;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sh     <= '0;
            r_fn     <= '0;
            r_result <= '0;
            r_out    <= '0;
            r_valid  <= 1'b0;
            // Treat the button as already down so a held button is no press
            r_btn_q  <= 1'b1;
`ifdef ALU_FLAGS_EN
            r_flags  <= 4'b0000;
`endif
        end else begin
            r_btn_q <= btn;
            case (r_state)
                S_LOAD_A: begin
                    if (w_press) begin
                        r_a[r_idx] <= in;
                        if (w_idx_last) begin
                            r_idx   <= '0;
                            r_state <= S_LOAD_B;
                        end else begin
                            r_idx <= w_idx_inc;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_press) begin
                        r_b[r_idx] <= in;
                        if (w_idx_last) begin
                            r_idx   <= '0;
                            r_state <= S_LOAD_SH;
                        end else begin
                            r_idx <= w_idx_inc;
                        end
                    end
                end
                S_LOAD_SH: begin
                    if (w_press) begin
                        r_sh    <= in[SH_W-1:0];
                        r_state <= S_LOAD_FN;
                    end
                end
                S_LOAD_FN: begin
                    if (w_press) begin
                        r_fn    <= in[3:0];
                        r_state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    // Button is deliberately ignored here
                    r_result <= w_result;
`ifdef ALU_FLAGS_EN
                    r_flags  <= w_flags;
`endif
                    r_out    <= w_result[BUS_W-1:0];
                    r_valid  <= 1'b1;
                    r_idx    <= '0;
                    r_state  <= S_SHOW;
                end
                S_SHOW: begin
                    if (w_press) begin
                        if (w_idx_last) begin
                            r_idx   <= '0;
                            r_out   <= '0;
                            r_valid <= 1'b0;
                            r_state <= S_LOAD_A;
                        end else begin
                            r_idx <= w_idx_inc;
                            r_out <= r_result[w_idx_inc];
                        end
                    end
                end
                default: begin
                    r_idx   <= '0;
                    r_out   <= '0;
                    r_valid <= 1'b0;
                    r_state <= S_LOAD_A;
                end
            endcase
        end
    end

    assign out   = r_out;
    assign phase = r_state;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_chunked.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_chunked
//  Description : Randomised bench for alu_chunked with an in-bench reference
//                model checked every cycle, plus directed literal cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_chunked;

    localparam int DATA_W = 32;
    localparam int BUS_W  = 16;
    localparam int CH     = DATA_W / BUS_W;
`ifdef ALU_FLAGS_EN
    localparam bit FL_EN = 1'b1;
`else
    localparam bit FL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             btn;
    logic [BUS_W-1:0] din;
    logic [BUS_W-1:0] dout;
    logic [2:0]       phase;
    logic             valid;
    logic [3:0]       flags;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_chunked #(.DATA_W(DATA_W), .BUS_W(BUS_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (din),
        .btn   (btn),
        .out   (dout),
        .phase (phase),
        .valid (valid),
        .flags (flags)
    );

    // ---------------- reference model ----------------
    int          m_phase;
    int          m_idx;
    logic [31:0] m_a, m_b, m_res;
    int          m_sh, m_fn;
    logic [3:0]  m_flags;
    bit          m_btnq;

    function automatic void model_alu(input logic [31:0] a, input logic [31:0] b,
                                      input int sh, input int fn,
                                      output logic [31:0] r, output logic [3:0] f);
        logic [32:0] w;
        longint      s;
        bit          c, v;
        c = 1'b0; v = 1'b0; r = '0;
        case (fn)
            0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0]; c = w[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s != longint'($signed(r)));
            end
            1: begin
                r = a - b; c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s != longint'($signed(r)));
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~a;
            6: begin
                w = {1'b0, a} << sh;
                r = w[31:0];
                c = (sh > 0) ? w[32] : 1'b0;
            end
            7: begin
                r = 32'(longint'($signed(a)) >>> sh);
                c = (sh > 0) ? a[sh-1] : 1'b0;
            end
            8: begin
                r = a >> sh;
                c = (sh > 0) ? a[sh-1] : 1'b0;
            end
            default: r = '0;
        endcase
        f = {r[31], (r == 32'd0), c, v};
        if (!FL_EN) f = 4'b0000;
    endfunction

    // Model state advances on the same edges as the DUT
    always @(posedge clk or posedge rst) begin : mdl
        bit p;
        if (rst) begin
            m_phase = 0; m_idx = 0; m_a = '0; m_b = '0; m_res = '0;
            m_sh = 0; m_fn = 0; m_flags = '0; m_btnq = 1'b1;
        end else begin
            p = btn && !m_btnq;
            m_btnq = btn;
            case (m_phase)
                0, 1: if (p) begin
                    if (m_phase == 0) m_a[m_idx*BUS_W +: BUS_W] = din;
                    else              m_b[m_idx*BUS_W +: BUS_W] = din;
                    if (m_idx == CH-1) begin m_idx = 0; m_phase = m_phase + 1; end
                    else m_idx = m_idx + 1;
                end
                2: if (p) begin m_sh = int'(din[4:0]); m_phase = 3; end
                3: if (p) begin m_fn = int'(din[3:0]); m_phase = 4; end
                4: begin
                    model_alu(m_a, m_b, m_sh, m_fn, m_res, m_flags);
                    m_idx = 0; m_phase = 5;
                end
                5: if (p) begin
                    if (m_idx == CH-1) begin m_idx = 0; m_phase = 0; end
                    else m_idx = m_idx + 1;
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(posedge clk) begin
        if (chk_en) begin
            #1;
            check("cyc_phase", 32'(phase), 32'(m_phase));
            check("cyc_valid", 32'(valid), 32'(m_phase == 5));
            check("cyc_out", 32'(dout),
                  (m_phase == 5) ? 32'(m_res[m_idx*BUS_W +: BUS_W]) : 32'd0);
            check("cyc_flags", 32'(flags), 32'(m_flags));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [15:0] v, input int hold);
        @(negedge clk);
        din = v; btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        din = 16'($urandom);
    endtask

    task automatic load_ops(input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh, input logic [3:0] fn, input int fh);
        logic [15:0] v;
        for (int i = 0; i < CH; i++) begin
            press(a[i*BUS_W +: BUS_W], 1); idle($urandom_range(0, 2));
        end
        for (int i = 0; i < CH; i++) begin
            press(b[i*BUS_W +: BUS_W], 1); idle($urandom_range(0, 2));
        end
        v = 16'($urandom); v[4:0] = sh;
        press(v, 1); idle($urandom_range(0, 2));
        v = 16'($urandom); v[3:0] = fn;
        press(v, fh);
    endtask

    task automatic wait_show();
        int k;
        k = 0;
        while (!valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("show_timeout", 32'(valid), 32'd1);
    endtask

    task automatic read_result(output logic [31:0] r, output logic [3:0] f);
        f = flags;
        r = '0;
        for (int i = 0; i < CH; i++) begin
            r[i*BUS_W +: BUS_W] = dout;
            idle($urandom_range(0, 1));
            press(16'($urandom), $urandom_range(1, 2));
        end
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [3:0] fn, input int fh,
                           output logic [31:0] r, output logic [3:0] f);
        load_ops(a, b, sh, fn, fh);
        wait_show();
        read_result(r, f);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        logic [31:0] r, er, a, b;
        logic [3:0]  f, ef;
        logic [4:0]  sh;
        logic [3:0]  fn;

        rst = 1'b0; btn = 1'b0; din = '0;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_out", 32'(dout), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        idle(2);

        // SUB 100-200 with chunked display
        load_ops(32'd100, 32'd200, 5'd0, 4'd1, 1);
        check("compute_phase", 32'(phase), 32'd4);
        @(negedge clk);
        check("show_latency", 32'(valid), 32'd1);
        check("sub_lo", 32'(dout), 32'h0000_FF9C);
        check("sub_flags", 32'(flags), FL_EN ? 32'b1000 : 32'd0);
        press(16'h0, 1);
        check("sub_hi", 32'(dout), 32'h0000_FFFF);
        press(16'h0, 1);
        check("show_end_phase", 32'(phase), 32'd0);
        check("show_end_out", 32'(dout), 32'd0);

        // Async reset while showing
        load_ops(32'h1234_5678, 32'h1, 5'd0, 4'd0, 1);
        wait_show();
        check("add_lo", 32'(dout), 32'h0000_5679);
        #2 rst = 1'b1;
        #1;
        check("arst_show_valid", 32'(valid), 32'd0);
        check("arst_show_out", 32'(dout), 32'd0);
        check("arst_show_phase", 32'(phase), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Shifts
        run_txn(32'h8000_0000, 32'($urandom), 5'd4, 4'd7, 1, r, f);
        check("sra_res", r, 32'hF800_0000);
        check("sra_flags", 32'(f), FL_EN ? 32'b1000 : 32'd0);
        run_txn(32'h8000_0000, 32'($urandom), 5'd4, 4'd8, 1, r, f);
        check("srl_res", r, 32'h0800_0000);
        check("srl_flags", 32'(f), 32'd0);

        // Add overflow and carry
        run_txn(32'h7FFF_FFFF, 32'h1, 5'd0, 4'd0, 1, r, f);
        check("ovf_res", r, 32'h8000_0000);
        check("ovf_flags", 32'(f), FL_EN ? 32'b1001 : 32'd0);
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 4'd0, 1, r, f);
        check("carry_res", r, 32'hFFFF_FFFE);
        check("carry_flags", 32'(f), FL_EN ? 32'b1010 : 32'd0);

        // Held button counts once
        press(16'h1234, 5);
        check("hold_once_phase", 32'(phase), 32'd0);
        press(16'h5678, 1);
        check("hold_second_phase", 32'(phase), 32'd1);
        press(16'hFFFF, 1); press(16'hFFFF, 1); press(16'h0, 1); press(16'h2, 1);
        wait_show();
        read_result(r, f);
        check("hold_res", r, 32'h5678_1234);

        // Button high across reset release is not a press
        din = 16'hAAAA; btn = 1'b1;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        idle(3);
        btn = 1'b0;
        check("btn_rst_phase", 32'(phase), 32'd0);
        run_txn(32'd5, 32'd7, 5'd0, 4'd0, 1, r, f);
        check("btn_rst_res", r, 32'd12);

        // Async reset mid LOAD_B
        press(16'h1111, 1); press(16'h2222, 1); press(16'h3333, 1);
        check("midb_phase", 32'(phase), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_b_phase", 32'(phase), 32'd0);
        check("arst_b_out", 32'(dout), 32'd0);
        check("arst_b_valid", 32'(valid), 32'd0);
        @(negedge clk) rst = 1'b0;
        run_txn(32'h0001_0003, 32'h0000_0005, 5'd0, 4'd4, 1, r, f);
        check("after_arst_res", r, 32'h0001_0006);

        // Undefined function code
        run_txn(32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 4'd12, 1, r, f);
        check("fn12_res", r, 32'd0);
        check("fn12_flags", 32'(f), FL_EN ? 32'b0100 : 32'd0);

        // Button held through COMPUTE and into SHOW does not advance display
        run_txn(32'h1111_2222, 32'h4444_0000, 5'd0, 4'd3, 3, r, f);
        check("hold_compute_res", r, 32'h5555_2222);

        // Randomised transactions
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b  = ($urandom_range(0, 4) == 0) ? a : $urandom;
            sh = 5'($urandom_range(0, 31));
            fn = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15))
                                             : 4'($urandom_range(0, 8));
            idle($urandom_range(0, 3));
            run_txn(a, b, sh, fn, $urandom_range(1, 2), r, f);
            model_alu(a, b, int'(sh), int'(fn), er, ef);
            check("rand_res", r, er);
            check("rand_flags", 32'(f), 32'(ef));
        end

        idle(2);
        chk_en = 1'b0;
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
